// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control unit.
// Holds the state encoding, opcodes, control-word bit map, ALU op codes and the per-state control word.
package cpu_pkg;

    localparam int OP_W        = 8;
    localparam int CTRL_WORD_W = 32;

    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        FETCH0  = 4'd1,
        FETCH1  = 4'd2,
        FETCH2  = 4'd3,
        DECODE  = 4'd4,
        EXEC0   = 4'd5,
        EXEC1   = 4'd6,
        EXEC2   = 4'd7,
        EXEC3   = 4'd8,
        HALT_S  = 4'd9
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP    = 8'h00;
    localparam logic [OP_W-1:0] OP_STORE  = 8'h01;
    localparam logic [OP_W-1:0] OP_LOAD   = 8'h02;
    localparam logic [OP_W-1:0] OP_ADD    = 8'h03;
    localparam logic [OP_W-1:0] OP_SUB    = 8'h04;
    localparam logic [OP_W-1:0] OP_JMPGEZ = 8'h05;
    localparam logic [OP_W-1:0] OP_JMP    = 8'h06;
    localparam logic [OP_W-1:0] OP_HALT   = 8'h07;
    localparam logic [OP_W-1:0] OP_AND    = 8'h09;
    localparam logic [OP_W-1:0] OP_OR     = 8'h0A;
    localparam logic [OP_W-1:0] OP_NOT    = 8'h0B;
    localparam logic [OP_W-1:0] OP_SHR    = 8'h0C;
    localparam logic [OP_W-1:0] OP_SHL    = 8'h0D;
    localparam logic [OP_W-1:0] OP_CLR    = 8'h0E;

    localparam int CTRL_PC_INC       = 0;
    localparam int CTRL_PC_LOAD      = 1;
    localparam int CTRL_MAR_FROM_PC  = 2;
    localparam int CTRL_MAR_FROM_MBR = 3;
    localparam int CTRL_MEM_RD       = 4;
    localparam int CTRL_MEM_WR       = 5;
    localparam int CTRL_MBR_FROM_MEM = 6;
    localparam int CTRL_MBR_FROM_ACC = 7;
    localparam int CTRL_IR_LOAD      = 8;
    localparam int CTRL_BR_FROM_MBR  = 9;
    localparam int CTRL_ACC_LOAD     = 10;
    localparam int CTRL_ALU_OP_LSB   = 11;
    localparam int CTRL_HALT         = 15;
    localparam int CTRL_ACC_CLR      = 21;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_NOT  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_SHL  = 3'd7
    } alu_op_t;

    // Opcodes that fetch an operand from memory before the ALU step.
    function automatic logic is_mem_alu_op(input logic [OP_W-1:0] op);
        return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

    function automatic alu_op_t alu_op_of(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOT:  return ALU_NOT;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            default: return ALU_PASS;
        endcase
    endfunction

    // Control word asserted while sitting in state s with opcode op in IR.
    function automatic logic [CTRL_WORD_W-1:0] ctrl_of(input state_t s, input logic [OP_W-1:0] op);
        logic [CTRL_WORD_W-1:0] c;
        c = '0;
        case (s)
            RESET_S: c[CTRL_ACC_CLR] = 1'b1;
            FETCH0:  c[CTRL_MAR_FROM_PC] = 1'b1;
            FETCH1: begin
                c[CTRL_MEM_RD]       = 1'b1;
                c[CTRL_MBR_FROM_MEM] = 1'b1;
            end
            FETCH2: begin
                c[CTRL_IR_LOAD] = 1'b1;
                c[CTRL_PC_INC]  = 1'b1;
            end
            EXEC0: begin
                if (op == OP_JMP || op == OP_JMPGEZ) c[CTRL_PC_LOAD] = 1'b1;
                else if (op == OP_CLR)               c[CTRL_ACC_CLR] = 1'b1;
                else                                 c[CTRL_MAR_FROM_MBR] = 1'b1;
            end
            EXEC1: begin
                if (op == OP_STORE) begin
                    c[CTRL_MBR_FROM_ACC] = 1'b1;
                end else begin
                    c[CTRL_MEM_RD]       = 1'b1;
                    c[CTRL_MBR_FROM_MEM] = 1'b1;
                end
            end
            EXEC2: begin
                if (op == OP_STORE) c[CTRL_MEM_WR] = 1'b1;
                else                c[CTRL_BR_FROM_MBR] = 1'b1;
            end
            EXEC3: begin
                c[CTRL_ACC_LOAD]               = 1'b1;
                c[CTRL_ALU_OP_LSB +: 3]        = alu_op_of(op);
            end
            HALT_S:  c[CTRL_HALT] = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational next-state and next-control-word logic for the control unit.
// With CU_MEM_WAIT_EN defined, memory states hold until mem_ready; otherwise they last one cycle.
module cu_decode
    import cpu_pkg::*;
(
    input  state_t                 state,
    input  logic [OP_W-1:0]        opcode,
    input  logic                   acc_neg,
    input  logic                   mem_ready,
    output state_t                 next_state,
    output logic [CTRL_WORD_W-1:0] ctrl_next,
    output logic                   illegal_next
);

    logic mem_done;

`ifdef CU_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done         = 1'b1;
`endif

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        next_state   = state;
        illegal_next = 1'b0;
        case (state)
            RESET_S: next_state = FETCH0;
            FETCH0:  next_state = FETCH1;
            FETCH1:  if (mem_done) next_state = FETCH2;
            FETCH2:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_JMP, OP_CLR:           next_state = EXEC0;
                    OP_NOT, OP_SHR, OP_SHL:   next_state = EXEC3;
                    OP_JMPGEZ:                next_state = acc_neg ? FETCH0 : EXEC0;
                    OP_NOP:                   next_state = FETCH0;
                    OP_HALT:                  next_state = HALT_S;
                    default: begin
                        next_state   = FETCH0;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            EXEC0:   next_state = is_mem_alu_op(opcode) || opcode == OP_STORE ? EXEC1 : FETCH0;
            EXEC1: begin
                if (opcode == OP_STORE) next_state = EXEC2;
                else if (mem_done)      next_state = EXEC2;
            end
            EXEC2: begin
                if (opcode != OP_STORE) next_state = EXEC3;
                else if (mem_done)      next_state = FETCH0;
            end
            EXEC3:   next_state = FETCH0;
            HALT_S:  next_state = HALT_S;
            default: next_state = RESET_S;
        endcase
    end

    // Registered output reflects the state being entered, so look it up by next_state.
    assign ctrl_next = ctrl_of(next_state, opcode);

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer producing the 32-bit datapath control word.
// Optional macro CU_MEM_WAIT_EN: memory states wait for mem_ready instead of lasting one cycle.
module cpu_control_unit #(
    parameter int OPCODE_W = 8,
    parameter int CTRL_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                acc_neg,
    input  logic                mem_ready,
    output logic [CTRL_W-1:0]   control_signal,
    output logic                halted,
    output logic                illegal_op,
    output logic [3:0]          state_dbg
);
    import cpu_pkg::*;

    state_t            state;
    state_t            next_state;
    logic [CTRL_W-1:0] ctrl_next;
    logic              illegal_next;

    cu_decode u_decode (
        .state        (state),
        .opcode       (opcode),
        .acc_neg      (acc_neg),
        .mem_ready    (mem_ready),
        .next_state   (next_state),
        .ctrl_next    (ctrl_next),
        .illegal_next (illegal_next)
    );

    // NOTE: reset is synchronous, so it is tested inside the clocked block and takes effect on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RESET_S;
            control_signal <= ctrl_of(RESET_S, '0);
            illegal_op     <= 1'b0;
        end else begin
            state          <= next_state;
            control_signal <= ctrl_next;
            illegal_op     <= illegal_next;
        end
    end

    assign halted    = (state == HALT_S);
    assign state_dbg = state;

endmodule
